instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: instruction width in bits.
REQ-002 Parameter DEPTH, default 16: program buffer entries; SHALL be a power of two, >= 2.
REQ-003 Parameter GAP, default 0: idle cycles inserted after each issued instruction.
REQ-004 Parameter NOP, default 0: value driven on next_instruction when nothing is issued.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 load_valid  in  1  write load_data into the buffer at the write pointer.
REQ-008 load_data  in  WIDTH  instruction to store.
REQ-009 load_ready  out  1  high when in IDLE and the buffer is not full.
REQ-010 start  in  1  begin playback of the stored program.
REQ-011 loop_count  in  8  number of additional passes; sampled on start.
REQ-012 clear  in  1  empty the buffer; honoured in IDLE or DONE only.
REQ-013 proc_ready  in  1  processor accepts the current instruction.
REQ-014 next_instruction  out  WIDTH  instruction presented to the processor.
REQ-015 instr_valid  out  1  next_instruction holds a program instruction.
REQ-016 busy  out  1  high in RUN or GAP.
REQ-017 done  out  1  high in DONE.
REQ-018 issued  out  16  count of accepted instructions since the last start, saturating.

Function
REQ-019 States SHALL be IDLE, RUN, GAP and DONE.
REQ-020 Load: load_valid && load_ready writes the entry and increments count; load_valid when not ready is dropped without side effects.
REQ-021 IDLE->RUN on start with count>0; start with count==0 goes directly to DONE with issued=0.
REQ-022 On start: read pointer=0, issued=0, pass counter=loop_count.
REQ-023 RUN: instr_valid=1 and next_instruction=buffer[read pointer], both driven from registers.
REQ-024 Transfer occurs on a cycle with instr_valid && proc_ready; next_instruction SHALL hold stable while proc_ready is low.
REQ-025 On transfer: issued increments (saturating at 16'hFFFF) and read pointer advances.
REQ-026 After a transfer with GAP>0: go to GAP, instr_valid=0, next_instruction=NOP, for exactly GAP cycles, then return to RUN.
REQ-027 With GAP=0, back-to-back transfers SHALL sustain one instruction per cycle.
REQ-028 Transfer of the last entry (read pointer==count-1): if pass counter>0, decrement it and set read pointer=0; otherwise go to DONE, after the gap if GAP>0.
REQ-029 DONE: done=1, instr_valid=0; start re-runs the same program (buffer preserved); clear returns to IDLE with count=0.
REQ-030 Buffer full (count==DEPTH): load_ready=0; write pointer wraps to 0 only through clear.
REQ-031 start and load_valid in the same IDLE cycle: the load is performed and the new entry is included in playback.
REQ-032 clear and start in the same cycle: clear wins; stay in or return to IDLE.
REQ-033 start, clear and load_valid SHALL be ignored during RUN and GAP.
REQ-034 When instr_valid=0, next_instruction SHALL equal NOP.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, count=0, all pointers=0, pass counter=0 and issued=0.
REQ-036 After reset: instr_valid=0, next_instruction=NOP, busy=0, done=0, load_ready=1.
REQ-037 Reset during RUN SHALL abandon playback with no further transfers; buffer contents are don't-care.

Structure
REQ-038 The state enumeration type and the NOP encoding (32'h0000_0000, sll $0,$0,0) SHALL live in the shared processor package.
REQ-039 Program storage SHALL be a sub-module, prog_buffer: a DEPTH x WIDTH register array with one write port and one read port, without reset on data.
REQ-040 The existing testbench helper tasks SHALL remain usable alongside this block; it does not replace them.

Verification
REQ-041 Load 3 instructions (8C010004, 00221820, AC030008), GAP=0, proc_ready=1, start -> three consecutive valid cycles in load order, issued=3, then done=1.
REQ-042 Same program with GAP=2 -> each instruction is followed by 2 cycles of instr_valid=0 and next_instruction=0; the sequence spans 9 cycles.
REQ-043 proc_ready low for 4 cycles during the 2nd instruction -> 00221820 is held stable; issued does not change until proc_ready rises.
REQ-044 loop_count=2 with 2 instructions -> 6 transfers in the order A,B,A,B,A,B; issued=6.
REQ-045 Fill DEPTH=16 entries -> load_ready=0; a 17th load is dropped; playback yields 16 transfers.
REQ-046 rst_n asserted in the cycle after the 2nd transfer -> instr_valid=0 within the same cycle (asynchronously); IDLE, issued=0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// the processor NOP encoding and a saturating counter helper.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // sll $0,$0,0 -- the canonical no-op of the target processor
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int LOOP_W   = 8;
  localparam int ISSUED_W = 16;

  function automatic logic [ISSUED_W-1:0] sat_inc(input logic [ISSUED_W-1:0] v);
    return (v == '1) ? v : v + ISSUED_W'(1);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Load, control and processor-side handshake signals of the sequencer.
// master = the environment driving the sequencer, slave = the sequencer.
interface instr_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             start;
  logic [7:0]       loop_count;
  logic             clear;
  logic             proc_ready;
  logic [WIDTH-1:0] next_instruction;
  logic             instr_valid;
  logic             busy;
  logic             done;
  logic [15:0]      issued;

  modport master (
    output load_valid, load_data, start, loop_count, clear, proc_ready,
    input  load_ready, next_instruction, instr_valid, busy, done, issued
  );

  modport slave (
    input  load_valid, load_data, start, loop_count, clear, proc_ready,
    output load_ready, next_instruction, instr_valid, busy, done, issued
  );
endinterface

// File: rtl/instr_sequencer_prog_buffer.sv
// Program storage: DEPTH x WIDTH register array, one write port, one
// combinational read port. Data is deliberately not reset.
module prog_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers a program, then plays it to a processor
// over a valid/ready handshake, optionally looping and inserting idle gaps.
//
//   state | meaning
//   IDLE  | accepting loads, waiting for start
//   RUN   | presenting buffer[rd_ptr] with instr_valid=1
//   GAP   | idle cycles after a transfer (GAP > 0 only)
//   DONE  | program finished; start re-runs, clear empties the buffer
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter int              DEPTH = 16,
  parameter int              GAP   = 0,
  parameter logic [WIDTH-1:0] NOP  = WIDTH'(NOP_INSTR)
) (
  input logic              clk,
  input logic              rst_n,
  instr_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LOOP_W-1:0]  pass_q, pass_d;
  logic [ISSUED_W-1:0] issued_q, issued_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               end_q, end_d;     // current gap ends in DONE
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   instr_q, instr_d;

  logic             load_ready;
  logic             do_load;
  logic             last_entry;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] rd_word;

  assign load_ready = (state_q == ST_IDLE) && (count_q != FULL);
  assign do_load    = bus.load_valid && load_ready && !bus.clear;
  assign last_entry = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  // A load coinciding with start may target the entry being read first;
  // the array only updates at the edge, so forward the incoming word.
  assign rd_word = (do_load && (count_q[AW-1:0] == rd_ptr_d)) ? bus.load_data : rd_data;

  prog_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (do_load),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (bus.load_data),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  // next-state, pointer/counter updates and registered output values
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    issued_d = issued_q;
    gap_d    = gap_q;
    end_d    = end_q;

    if (do_load) count_d = count_q + CW'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.clear) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (bus.start) begin
          rd_ptr_d = '0;
          issued_d = '0;
          pass_d   = bus.loop_count;
          end_d    = 1'b0;
          state_d  = (count_d != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.proc_ready) begin
          issued_d = sat_inc(issued_q);
          end_d    = 1'b0;
          if (last_entry) begin
            rd_ptr_d = '0;
            if (pass_q != '0) pass_d = pass_q - LOOP_W'(1);
            else              end_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
          end else begin
            state_d = end_d ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = end_q ? ST_DONE : ST_RUN;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_RUN);
    instr_d = valid_d ? rd_word : NOP;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      issued_q <= '0;
      gap_q    <= '0;
      end_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= NOP;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      issued_q <= issued_d;
      gap_q    <= gap_d;
      end_q    <= end_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
    end
  end

  assign bus.load_ready       = load_ready;
  assign bus.next_instruction = instr_q;
  assign bus.instr_valid      = valid_q;
  assign bus.busy             = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign bus.done             = (state_q == ST_DONE);
  assign bus.issued           = issued_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: two instances (GAP=0 and GAP=2) share all
// inputs; a stream-level reference model checks every cycle of playback.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int W = 32;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         start      = 1'b0;
  logic [7:0]   loop_count = '0;
  logic         clear      = 1'b0;
  logic         proc_ready = 1'b0;

  instr_sequencer_if #(.WIDTH(W)) bus0 ();
  instr_sequencer_if #(.WIDTH(W)) bus2 ();

  assign bus0.load_valid = load_valid;
  assign bus0.load_data  = load_data;
  assign bus0.start      = start;
  assign bus0.loop_count = loop_count;
  assign bus0.clear      = clear;
  assign bus0.proc_ready = proc_ready;
  assign bus2.load_valid = load_valid;
  assign bus2.load_data  = load_data;
  assign bus2.start      = start;
  assign bus2.loop_count = loop_count;
  assign bus2.clear      = clear;
  assign bus2.proc_ready = proc_ready;

  instr_sequencer #(.WIDTH(W), .DEPTH(D), .GAP(0), .NOP(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_sequencer #(.WIDTH(W), .DEPTH(D), .GAP(2), .NOP(32'h0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // reference model: the program as loaded, and per-instance stream progress
  logic [W-1:0] prog [D];
  int nprog = 0;
  int loops_cur = 0;
  int total = 0;
  int idx [2];
  int gleft [2];
  int cyc [2];
  bit fin [2];

  localparam logic [W-1:0] PA = 32'h8C01_0004;
  localparam logic [W-1:0] PB = 32'h0022_1820;
  localparam logic [W-1:0] PC = 32'hAC03_0008;

  typedef struct {
    int attempts;   // load attempts (beyond DEPTH are expected to drop)
    int loops;
    int exp_issued;
    int exp_cyc0;   // non-DONE cycles with GAP=0 and proc_ready always high
    int exp_cyc2;   // same with GAP=2
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return ($urandom_range(0, 99) < 70);
    if (mode == 2) return !(c >= 1 && c <= 4);
    return 1'b1;
  endfunction

  function automatic bit model_busy(input int d);
    return (gleft[d] > 0) || (idx[d] < total);
  endfunction

  task automatic check_dut(input int d, input logic v, input logic [W-1:0] nx,
                           input logic [15:0] iss, input logic bz, input logic dn);
    chk($sformatf("d%0d_issued", d), 32'(iss), 32'(idx[d]));
    chk($sformatf("d%0d_busy", d), 32'(bz), 32'(model_busy(d)));
    if (gleft[d] > 0) begin
      chk($sformatf("d%0d_gap_valid", d), 32'(v), 32'd0);
      chk($sformatf("d%0d_gap_nop", d), nx, NOP_INSTR);
      gleft[d]--;
      cyc[d]++;
    end else if (idx[d] < total) begin
      chk($sformatf("d%0d_run_valid", d), 32'(v), 32'd1);
      chk($sformatf("d%0d_instr%0d", d, idx[d]), nx, prog[idx[d] % nprog]);
      cyc[d]++;
      if (proc_ready) begin
        idx[d]++;
        gleft[d] = gap_of(d);
      end
    end else begin
      chk($sformatf("d%0d_done", d), 32'(dn), 32'd1);
      chk($sformatf("d%0d_done_valid", d), 32'(v), 32'd0);
      chk($sformatf("d%0d_done_nop", d), nx, NOP_INSTR);
      fin[d] = 1'b1;
    end
  endtask

  task automatic load_word(input logic [W-1:0] w);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    chk("load_ready0", 32'(bus0.load_ready), 32'(nprog < D));
    chk("load_ready2", 32'(bus2.load_ready), 32'(nprog < D));
    if (nprog < D) begin
      prog[nprog] = w;
      nprog++;
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic do_clear(input logic with_start);
    @(posedge clk); #1;
    clear = 1'b1;
    start = with_start;
    @(posedge clk); #1;
    clear = 1'b0;
    start = 1'b0;
    nprog = 0;
    @(negedge clk);
    chk("clr_ready", 32'(bus0.load_ready), 32'd1);
    chk("clr_done", 32'(bus0.done), 32'd0);
    chk("clr_busy", 32'(bus2.busy), 32'd0);
    chk("clr_valid", 32'(bus0.instr_valid), 32'd0);
  endtask

  // pulse start (optionally with a simultaneous load); returns at edge+1
  task automatic kick(input int loops, input bit with_load, input logic [W-1:0] w);
    @(posedge clk); #1;
    start      = 1'b1;
    loop_count = 8'(loops);
    loops_cur  = loops;
    if (with_load) begin
      load_valid = 1'b1;
      load_data  = w;
      if (nprog < D) begin
        prog[nprog] = w;
        nprog++;
      end
    end
    @(posedge clk); #1;
    start      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic run_check(input int mode, input int e0, input int e2);
    int c;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; gleft[d] = 0; cyc[d] = 0; fin[d] = 1'b0;
    end
    total = nprog * (loops_cur + 1);
    c = 0;
    proc_ready = ready_for(mode, 0);
    while (!(fin[0] && fin[1]) && c < 2000) begin
      @(negedge clk);
      check_dut(0, bus0.instr_valid, bus0.next_instruction, bus0.issued, bus0.busy, bus0.done);
      check_dut(1, bus2.instr_valid, bus2.next_instruction, bus2.issued, bus2.busy, bus2.done);
      @(posedge clk); #1;
      c++;
      proc_ready = ready_for(mode, c);
      if (mode == 1 && model_busy(0) && model_busy(1)) begin
        start      = ($urandom_range(0, 3) == 0);
        clear      = ($urandom_range(0, 3) == 0);
        load_valid = ($urandom_range(0, 1) == 0);
        load_data  = $urandom;
      end else begin
        start = 1'b0; clear = 1'b0; load_valid = 1'b0;
      end
    end
    start = 1'b0; clear = 1'b0; load_valid = 1'b0;
    if (!(fin[0] && fin[1])) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got cycles=%0d want completion", c);
    end
    if (e0 >= 0) chk("cycles_gap0", 32'(cyc[0]), 32'(e0));
    if (e2 >= 0) chk("cycles_gap2", 32'(cyc[1]), 32'(e2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3, 0, 3, 3, 9};
    vt[1] = '{2, 2, 6, 6, 18};
    vt[2] = '{17, 0, 16, 16, 48};
    vt[3] = '{0, 3, 0, 0, 0};
    vt[4] = '{1, 4, 5, 5, 15};
    vt[5] = '{5, 1, 10, 10, 30};

    // reset state, sampled while reset is held
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus0.instr_valid), 32'd0);
    chk("rst_nop", bus0.next_instruction, NOP_INSTR);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus2.done), 32'd0);
    chk("rst_ready", 32'(bus0.load_ready), 32'd1);
    chk("rst_issued", 32'(bus2.issued), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed table with proc_ready held high
    for (int r = 0; r < 6; r++) begin
      do_clear(1'b0);
      for (int i = 0; i < vt[r].attempts; i++) begin
        logic [W-1:0] w;
        if (r < 2 && i == 0)      w = PA;
        else if (r < 2 && i == 1) w = PB;
        else if (r < 2 && i == 2) w = PC;
        else                      w = $urandom;
        load_word(w);
      end
      kick(vt[r].loops, 1'b0, '0);
      run_check(0, vt[r].exp_cyc0, vt[r].exp_cyc2);
      chk($sformatf("row%0d_issued0", r), 32'(bus0.issued), 32'(vt[r].exp_issued));
      chk($sformatf("row%0d_issued2", r), 32'(bus2.issued), 32'(vt[r].exp_issued));
    end

    // back-pressure: proc_ready low for 4 cycles while B is presented
    do_clear(1'b0);
    load_word(PA); load_word(PB); load_word(PC);
    kick(0, 1'b0, '0);
    run_check(2, 7, 11);

    // start and load in the same cycle from an empty buffer, then re-run from DONE
    do_clear(1'b0);
    kick(1, 1'b1, 32'hDEAD_BEEF);
    run_check(0, 2, 6);
    kick(0, 1'b0, '0);
    run_check(0, 1, 3);
    chk("rerun_issued", 32'(bus0.issued), 32'd1);

    // clear and start together in DONE: clear wins
    do_clear(1'b1);

    // randomized programs, loop counts, back-pressure and ignored inputs
    for (int t = 0; t < 8; t++) begin
      int n;
      do_clear(1'($urandom_range(0, 1)));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_word($urandom);
      kick($urandom_range(0, 3), 1'b0, '0);
      run_check(1, -1, -1);
      chk($sformatf("rand%0d_issued", t), 32'(bus0.issued), 32'(total));
    end

    // asynchronous reset in the cycle after the second transfer
    do_clear(1'b0);
    load_word(PA); load_word(PB); load_word(PC);
    kick(0, 1'b0, '0);
    proc_ready = 1'b1;
    @(negedge clk);
    chk("rr_first", bus0.next_instruction, PA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_second", bus0.next_instruction, PB);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rr_valid", 32'(bus0.instr_valid), 32'd0);
    chk("rr_nop", bus0.next_instruction, NOP_INSTR);
    chk("rr_issued", 32'(bus0.issued), 32'd0);
    chk("rr_busy", 32'(bus0.busy), 32'd0);
    chk("rr_valid2", 32'(bus2.instr_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_idle_ready", 32'(bus0.load_ready), 32'd1);
    chk("rr_no_transfer", 32'(bus0.instr_valid), 32'd0);
    chk("rr_done", 32'(bus0.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
